// File: rtl/ram_pix_writer.sv
// ram_pix_writer: buffers a 16-bit pixel stream in a small FIFO and writes it
// into consecutive RAM blocks through RAMController's write command/handshake.
// Ports: clk, rst_ (async active-low); ctrl_start/ctrl_block/ctrl_block_count,
// busy, done (control); pix_valid/pix_ready/pix_data (pixel input);
// ram_cmd, ram_cmd_block, ram_write_ready/trigger/data (controller side).
module ram_pix_writer #(
    parameter int         BlockSize = 16,
    parameter int         FifoDepth = 8,
    parameter logic [1:0] CmdNone   = 2'd0,
    parameter logic [1:0] CmdWrite  = 2'd2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        ctrl_start,
    input  logic [20:0] ctrl_block,
    input  logic [20:0] ctrl_block_count,
    output logic        busy,
    output logic        done,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic [1:0]  ram_cmd,
    output logic [20:0] ram_cmd_block,
    input  logic        ram_write_ready,
    output logic        ram_write_trigger,
    output logic [15:0] ram_write_data
);

    localparam int IW = (BlockSize > 1) ? $clog2(BlockSize) : 1;
    localparam int AW = $clog2(FifoDepth);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [IW-1:0] LAST_IDX = IW'(BlockSize - 1);

    logic [2:0]    state;
    logic [20:0]   block;
    logic [20:0]   blocks_left;
    logic [36:0]   pix_left;
    logic [IW-1:0] word_idx;

    logic [15:0]   mem [FifoDepth];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign pix_ready         = busy && !fifo_full && (pix_left != '0);
    assign ram_cmd           = (state == S_CMD) ? CmdWrite : CmdNone;
    assign ram_cmd_block     = block;
    assign ram_write_trigger = (state == S_STREAM) && !fifo_empty;
    assign ram_write_data    = mem[rd_ptr[AW-1:0]];

    assign push = pix_valid && pix_ready;
    assign pop  = ram_write_trigger && ram_write_ready;

    // FIFO storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= pix_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pix_left <= '0;
        end else if (state == S_IDLE) begin
            if (ctrl_start) begin
                pix_left <= 37'(ctrl_block_count) * 37'(BlockSize);
            end
        end else if (push) begin
            pix_left <= pix_left - 37'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= S_IDLE;
            block       <= '0;
            blocks_left <= '0;
            word_idx    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        block       <= ctrl_block;
                        blocks_left <= ctrl_block_count;
                        state       <= (ctrl_block_count != '0) ? S_CMD : S_DONE;
                    end
                end
                S_CMD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    word_idx <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (pop) begin
                        word_idx <= word_idx + IW'(1);
                        if (word_idx == LAST_IDX) begin
                            blocks_left <= blocks_left - 21'd1;
                            block       <= block + 21'd1;
                            state       <= (blocks_left == 21'd1) ? S_DONE : S_CMD;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_pix_writer.sv
// tb_ram_pix_writer: directed captures with randomized pixel/ready timing,
// checked every cycle against a transaction-level model of the writer.
module tb_ram_pix_writer;

    localparam int         BS = 16;
    localparam int         FD = 8;
    localparam logic [1:0] CN = 2'd0;
    localparam logic [1:0] CW = 2'd2;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ctrl_start;
    logic [20:0] ctrl_block;
    logic [20:0] ctrl_block_count;
    logic        busy;
    logic        done;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [1:0]  ram_cmd;
    logic [20:0] ram_cmd_block;
    logic        ram_write_ready;
    logic        ram_write_trigger;
    logic [15:0] ram_write_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_pix_writer #(.BlockSize(BS), .FifoDepth(FD)) dut (
        .clk              (clk),
        .rst_             (rst_),
        .ctrl_start       (ctrl_start),
        .ctrl_block       (ctrl_block),
        .ctrl_block_count (ctrl_block_count),
        .busy             (busy),
        .done             (done),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_data         (pix_data),
        .ram_cmd          (ram_cmd),
        .ram_cmd_block    (ram_cmd_block),
        .ram_write_ready  (ram_write_ready),
        .ram_write_trigger(ram_write_trigger),
        .ram_write_data   (ram_write_data)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_prdy"},  pix_ready, 0);
        chk({tag, "_cmd"},   ram_cmd, CN);
        chk({tag, "_cblk"},  ram_cmd_block, 0);
        chk({tag, "_trig"},  ram_write_trigger, 0);
        chk({tag, "_wdata"}, ram_write_data, 0);
    endtask

    // vmode: 0 valid always (data 0x1000+i), 1 every 3rd cycle, 2 random
    // rmode: 0 ready always, 1 random, 2 20-cycle stall in first block
    // inj:   cycle at which a stray ctrl_start is pulsed (0 = none)
    // abort: block number during which reset is asserted (0 = none)
    task automatic run_capture(input logic [20:0] base, input int cnt,
                               input int vmode, input int rmode,
                               input int inj, input int abort);
        logic [15:0] q[$];
        int occ = 0;
        int pushed = 0;
        int xfers = 0;
        int cmds = 0;
        int c = 0;
        int last_x = -10;
        int last_cmd = -10;
        int stall_from = -1;
        int total_w = cnt * BS;
        bit exp_cmd, exp_done, exp_stream, exp_trig, exp_rdy;
        bit push, pop;
        bit fin = 0;
        logic [20:0] eb;
        @(negedge clk);
        ctrl_start = 1'b1;
        ctrl_block = base;
        ctrl_block_count = 21'(cnt);
        pix_valid = 1'b0;
        ram_write_ready = 1'b1;
        forever begin
            @(negedge clk);
            c++;
            if (c == 1 || c == inj + 1) ctrl_start = 1'b0;
            if (fin) begin
                chk("end_busy", busy, 0);
                chk("end_done", done, 0);
                chk("end_prdy", pix_ready, 0);
                chk("end_trig", ram_write_trigger, 0);
                chk("end_words", xfers, total_w);
                pix_valid = 1'b0;
                return;
            end
            if (c > 1500) begin
                chk("timeout", c, 0);
                pix_valid = 1'b0;
                return;
            end
            exp_cmd = (c == 1 && cnt > 0) ||
                      (last_x == c - 1 && xfers > 0 &&
                       xfers % BS == 0 && xfers < total_w);
            chk("cmd", ram_cmd, exp_cmd ? CW : CN);
            if (exp_cmd) begin
                eb = base + 21'(cmds);
                chk("cmd_block", ram_cmd_block, eb);
                cmds++;
                last_cmd = c;
            end
            exp_done = (cnt == 0 && c == 1) ||
                       (total_w > 0 && xfers == total_w && last_x == c - 1);
            chk("done", done, exp_done);
            chk("busy", busy, 1);
            exp_rdy = (occ < FD) && (pushed < total_w);
            chk("pix_ready", pix_ready, exp_rdy);
            exp_stream = cmds > 0 && c >= last_cmd + 2 && xfers < cmds * BS;
            exp_trig = exp_stream && occ > 0;
            chk("trigger", ram_write_trigger, exp_trig);
            if (exp_trig) chk("wdata", ram_write_data, q[0]);
            if (exp_done) fin = 1;
            if (abort > 0 && cmds == abort && xfers >= (abort - 1) * BS + 3) begin
                pix_valid = 1'b0;
                #2 rst_ = 1'b0;
                #1 chk_reset_vals("async_rst");
                @(negedge clk);
                rst_ = 1'b1;
                return;
            end
            if (c == inj) begin
                ctrl_start = 1'b1;
                ctrl_block = 21'($urandom);
                ctrl_block_count = 21'($urandom_range(1, 9));
            end
            case (vmode)
                0: pix_valid = 1'b1;
                1: pix_valid = (c % 3 == 0);
                default: pix_valid = 1'($urandom_range(0, 1));
            endcase
            pix_data = (vmode == 0) ? 16'h1000 + 16'(pushed) : 16'($urandom);
            case (rmode)
                0: ram_write_ready = 1'b1;
                1: ram_write_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_from < 0 && xfers == 5) stall_from = c;
                    ram_write_ready = !(stall_from >= 0 && c < stall_from + 20);
                end
            endcase
            push = pix_valid && exp_rdy;
            pop  = exp_trig && ram_write_ready;
            if (pop) begin
                void'(q.pop_front());
                xfers++;
                last_x = c;
                occ--;
            end
            if (push) begin
                q.push_back(pix_data);
                pushed++;
                occ++;
            end
        end
    endtask

    initial begin
        rst_ = 1'b0;
        ctrl_start = 1'b0;
        ctrl_block = '0;
        ctrl_block_count = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        ram_write_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_ = 1'b1;

        run_capture(21'h000005, 1, 0, 0, 0, 0);
        run_capture(21'h1FFFFF, 3, 2, 1, 0, 0);
        run_capture(21'h000100, 2, 0, 2, 0, 0);
        run_capture(21'h000040, 2, 1, 0, 0, 0);
        run_capture(21'h000777, 0, 0, 0, 0, 0);
        run_capture(21'h000200, 2, 0, 1, 10, 0);
        run_capture(21'h000300, 4, 0, 1, 0, 2);
        run_capture(21'h000010, 1, 2, 0, 0, 0);
        run_capture(21'h0ABCDE, 2, 2, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
